axi4r_burst_reader: RTL and testbench

- AXI4 read master that sits directly upstream of an `axi4r_if` slave (memory/interconnect).
- Accepts a command (start address, beat count) and splits it into INCR bursts that respect a max-length limit and the 4 KB boundary.
- Forwards returned 64-bit read data as a valid/ready stream to a downstream consumer, and reports per-command completion and error status.
- Issues one burst at a time, so responses are strictly in order.

---
 rtl/axi4r_burst_reader.sv | 173 +++++++++++++++++
 tb/tb_axi4r_burst_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4r_burst_reader.sv
// AXI4 read master: splits a (start address, beat count) command into INCR bursts that
// respect MAX_BURST and 4 KB pages, and forwards R data as a zero-latency valid/ready stream.
module axi4r_burst_reader #(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [3:0]  ID        = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_beats,
  input  logic        m_arready,
  output logic        m_arvalid,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_rready,
  input  logic        m_rvalid,
  input  logic [1:0]  m_rresp,
  input  logic [63:0] m_rdata,
  input  logic        m_rlast,
  input  logic [3:0]  m_rid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a source holds
  // its payload stable while valid is high and not yet accepted.
  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  n_q, n_d;
  logic        err_q, err_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [8:0]  nxt_n;
  logic        unused_rid;

  // Burst size: limited by beats left, MAX_BURST and the beats left in the 4 KB page.
  function automatic logic [8:0] burst_n(input logic [31:0] a, input logic [15:0] rem);
    logic [12:0] room;
    logic [15:0] n;
    room = (13'd4096 - {1'b0, a[11:0]}) >> 3;
    n = rem;
    if (n > 16'(MAX_BURST)) n = 16'(MAX_BURST);
    if ({3'b000, room} < n) n = {3'b000, room};
    return n[8:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    err_d     = err_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    nxt_n     = '0;
    cmd_ready = 1'b0;
    m_rready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        err_d     = 1'b0;
        if (cmd_valid) begin
          if (cmd_beats == 16'd0) begin
            state_d = FIN;
          end else begin
            nxt_n     = burst_n(cmd_addr, cmd_beats);
            addr_d    = cmd_addr;
            rem_d     = cmd_beats;
            n_d       = nxt_n;
            araddr_d  = cmd_addr;
            arlen_d   = 8'(nxt_n - 9'd1);
            arvalid_d = 1'b1;
            state_d   = ADDR;
          end
        end
      end
      ADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          cnt_d     = n_q;
          addr_d    = addr_q + {20'd0, n_q, 3'b000};
          rem_d     = rem_q - {7'd0, n_q};
          state_d   = DATA;
        end
      end
      DATA: begin
        out_valid = m_rvalid;
        m_rready  = out_ready;
        out_last  = m_rvalid && (cnt_q == 9'd1) && (rem_q == 16'd0);
        if (m_rvalid && out_ready) begin
          cnt_d = cnt_q - 9'd1;
          if (m_rresp != 2'b00) err_d = 1'b1;
          // The beat count, not m_rlast, decides where a burst ends; a disagreement is only flagged.
          if (m_rlast != (cnt_q == 9'd1)) err_d = 1'b1;
          if (cnt_q == 9'd1) begin
            if (rem_q != 16'd0) begin
              nxt_n     = burst_n(addr_q, rem_q);
              n_d       = nxt_n;
              araddr_d  = addr_q;
              arlen_d   = 8'(nxt_n - 9'd1);
              arvalid_d = 1'b1;
              state_d   = ADDR;
            end else begin
              state_d = FIN;
            end
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      err_q     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      err_q     <= err_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
    end
  end

  assign m_arvalid  = arvalid_q;
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arid     = ID;
  assign m_arsize   = 3'd3;
  assign m_arburst  = 2'b01;
  assign out_data   = m_rdata;
  assign dbg_state  = state_q;
  assign unused_rid = ^m_rid;

endmodule

// File: tb/tb_axi4r_burst_reader.sv
// Bench for axi4r_burst_reader: random AXI slave and stream sink, with a behavioural model
// of the burst split and data stream checked every cycle.
module tb_axi4r_burst_reader;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        m_arready = 1'b0;
  logic        m_arvalid;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rready;
  logic        m_rvalid = 1'b0;
  logic [1:0]  m_rresp = 2'b00;
  logic [63:0] m_rdata = '0;
  logic        m_rlast = 1'b0;
  logic [3:0]  m_rid = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        done, err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  axi4r_burst_reader #(.MAX_BURST(MAXB), .ID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .m_arready(m_arready), .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rready(m_rready), .m_rvalid(m_rvalid), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [39:0] plan_q[$];   // {araddr, arlen}
  logic [39:0] exp_ar_q[$];
  logic [64:0] exp_d_q[$];  // {last, data}

  function automatic int burst_len(input logic [31:0] a, input int rem);
    int room;
    int n;
    room = (4096 - int'(a[11:0])) / 8;
    n = rem;
    if (n > MAXB) n = MAXB;
    if (n > room) n = room;
    return n;
  endfunction

  task automatic build_plan(input logic [31:0] a, input int beats);
    logic [31:0] pa;
    int rem;
    int n;
    plan_q.delete();
    pa  = a;
    rem = beats;
    while (rem > 0) begin
      n = burst_len(pa, rem);
      plan_q.push_back({pa, 8'(n - 1)});
      pa  = pa + 32'(8 * n);
      rem = rem - n;
    end
  endtask

  // command configuration handed from the driver to the slave/model at accept time
  logic [31:0] cur_salt = '0;
  int cur_err_beat = -1;
  int cur_flip_beat = -1;
  int rdy_mode = 1;

  bit          busy = 0, done_due = 0, exp_err = 0, fin_now = 0;
  bit          s_active = 0, s_rv_hold = 0;
  logic [31:0] s_addr = '0, s_salt = '0;
  int          s_left = 0, s_idx = 0, s_err_beat = -1, s_flip_beat = -1;
  int          acc_cnt = 0, done_cnt = 0, ar_cnt = 0;
  logic        last_err = 1'b0;
  logic [64:0] e;

  // Slave + sink driver and the single compare process.
  always begin
    @(negedge clk);
    m_arready = ($urandom_range(0, 3) != 0);
    m_rid     = 4'($urandom_range(0, 15));
    if (s_active && (s_rv_hold || $urandom_range(0, 9) < 7)) begin
      m_rvalid = 1'b1;
      m_rdata  = {s_salt, s_addr};
      m_rresp  = (s_idx == s_err_beat) ? 2'b10 : 2'b00;
      m_rlast  = (s_left == 1) ^ (s_idx == s_flip_beat);
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = {$urandom, $urandom};
      m_rresp  = 2'($urandom_range(0, 3));
      m_rlast  = 1'($urandom_range(0, 1));
    end
    case (rdy_mode)
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    if (rst) begin
      check_eq("rst_cmd_ready", cmd_ready, 1);
      check_eq("rst_arvalid", m_arvalid, 0);
      check_eq("rst_araddr", m_araddr, 0);
      check_eq("rst_arlen", m_arlen, 0);
      check_eq("rst_rready", m_rready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_last", out_last, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      busy = 0; done_due = 0; s_active = 0; s_rv_hold = 0;
      exp_ar_q.delete();
      exp_d_q.delete();
    end else begin
      check_eq("done", done, done_due);
      if (done_due) begin
        check_eq("err", err, exp_err);
        check_eq("beats_left_at_done", exp_d_q.size(), 0);
        check_eq("ars_left_at_done", exp_ar_q.size(), 0);
      end
      fin_now  = done_due;
      done_due = 0;
      check_eq("cmd_ready", cmd_ready, !busy);
      if (fin_now) begin
        busy = 0;
        done_cnt++;
        last_err = err;
      end

      // R channel / output stream
      check_eq("out_valid", out_valid, m_rvalid);
      check_eq("m_rready", m_rready, s_active && out_ready);
      if (m_rvalid && m_rready) begin
        check_eq("beat_expected", exp_d_q.size() != 0, 1);
        if (exp_d_q.size() != 0) begin
          e = exp_d_q.pop_front();
          check_eq("out_data", out_data, e[63:0]);
          check_eq("out_last", out_last, e[64]);
          if (exp_d_q.size() == 0) done_due = 1;
        end
        s_rv_hold = 0;
        s_idx++;
        s_addr = s_addr + 32'd8;
        s_left--;
        if (s_left == 0) s_active = 0;
      end else begin
        s_rv_hold = m_rvalid;
        if (out_valid && exp_d_q.size() != 0) check_eq("out_last_stall", out_last, exp_d_q[0][64]);
        else if (!out_valid) check_eq("out_last_idle", out_last, 0);
      end

      // AR channel
      if (m_arvalid) begin
        check_eq("arid", m_arid, 0);
        check_eq("arsize", m_arsize, 3);
        check_eq("arburst", m_arburst, 1);
        check_eq("ar_while_data", s_active, 0);
        check_eq("ar_expected", exp_ar_q.size() != 0, 1);
        if (exp_ar_q.size() != 0) check_eq("ar_addr_len", {m_araddr, m_arlen}, exp_ar_q[0]);
        if (m_arready) begin
          if (exp_ar_q.size() != 0) void'(exp_ar_q.pop_front());
          ar_cnt++;
          s_active = 1;
          s_addr   = m_araddr;
          s_left   = int'(m_arlen) + 1;
        end
      end

      // command accept
      if (cmd_valid && cmd_ready) begin
        acc_cnt++;
        busy        = 1;
        s_idx       = 0;
        s_salt      = cur_salt;
        s_err_beat  = cur_err_beat;
        s_flip_beat = cur_flip_beat;
        exp_err     = 0;
        for (int k = 0; k < int'(cmd_beats); k++) begin
          exp_d_q.push_back({k == int'(cmd_beats) - 1, cur_salt, cmd_addr + 32'(8 * k)});
          if (k == cur_err_beat || k == cur_flip_beat) exp_err = 1;
        end
        build_plan(cmd_addr, int'(cmd_beats));
        foreach (plan_q[j]) exp_ar_q.push_back(plan_q[j]);
        if (cmd_beats == 16'd0) done_due = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_cmd(input logic [31:0] a, input int beats, input int eb, input int fb,
                         input int mode, input bit wait_done);
    int start_acc;
    int start_done;
    int cyc;
    cur_salt      = $urandom;
    cur_err_beat  = eb;
    cur_flip_beat = fb;
    rdy_mode      = mode;
    start_acc     = acc_cnt;
    start_done    = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = 16'(beats);
    cyc = 0;
    while (acc_cnt == start_acc && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    cmd_valid = 1'b0;
    check_eq("cmd_accepted", acc_cnt != start_acc, 1);
    if (wait_done) begin
      cyc = 0;
      while (done_cnt == start_done && cyc < 5000) begin
        @(posedge clk);
        cyc++;
      end
      check_eq("cmd_done", done_cnt != start_done, 1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int ar0, done0, cyc;
  logic [31:0] ra;
  int rb, reb, rfb;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_beats = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Model pins: hand-computed burst splits.
    build_plan(32'h1000, 4);
    check_eq("plan1_n", plan_q.size(), 1);
    check_eq("plan1_0", plan_q[0], {32'h1000, 8'd3});
    build_plan(32'h0, 40);
    check_eq("plan2_n", plan_q.size(), 3);
    check_eq("plan2_0", plan_q[0], {32'h000, 8'd15});
    check_eq("plan2_1", plan_q[1], {32'h080, 8'd15});
    check_eq("plan2_2", plan_q[2], {32'h100, 8'd7});
    build_plan(32'h0FF0, 4);
    check_eq("plan3_n", plan_q.size(), 2);
    check_eq("plan3_0", plan_q[0], {32'h0FF0, 8'd1});
    check_eq("plan3_1", plan_q[1], {32'h1000, 8'd1});
    build_plan(32'hFFFF_FFF8, 3);
    check_eq("plan_wrap_0", plan_q[0], {32'hFFFF_FFF8, 8'd0});
    check_eq("plan_wrap_1", plan_q[1], {32'h0, 8'd1});
    build_plan(32'h0F80, 16);
    check_eq("plan_edge_n", plan_q.size(), 1);

    // Directed commands
    ar0 = ar_cnt; run_cmd(32'h1000, 4, -1, -1, 1, 1);
    check_eq("t1_ars", ar_cnt - ar0, 1);
    check_eq("t1_err", last_err, 0);
    ar0 = ar_cnt; run_cmd(32'h0, 40, -1, -1, 0, 1);
    check_eq("t2_ars", ar_cnt - ar0, 3);
    ar0 = ar_cnt; run_cmd(32'h0FF0, 4, -1, -1, 0, 1);
    check_eq("t3_ars", ar_cnt - ar0, 2);
    ar0 = ar_cnt; run_cmd(32'h2000, 0, -1, -1, 1, 1);
    check_eq("t4_ars", ar_cnt - ar0, 0);
    check_eq("t4_err", last_err, 0);
    ar0 = ar_cnt; run_cmd(32'h2000, 3, 1, -1, 2, 1);
    check_eq("t5_err", last_err, 1);
    run_cmd(32'hFFFF_FFF8, 3, -1, -1, 0, 1);
    run_cmd(32'h0F80, 16, -1, -1, 0, 1);
    run_cmd(32'h0500, 5, -1, 2, 0, 1);
    check_eq("t_flip_err", last_err, 1);
    run_cmd(32'h0000_0FC0, 20, -1, -1, 0, 1);
    run_cmd(32'h0000_0008, 300, -1, -1, 1, 1);
    check_eq("t_long_err", last_err, 0);

    // Reset in the middle of a burst
    done0 = done_cnt;
    run_cmd(32'h3000, 8, -1, -1, 1, 0);
    cyc = 0;
    while (s_idx < 2 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("rst_reach_beat2", s_idx >= 2, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("no_done_on_rst", done_cnt, done0);
    run_cmd(32'h3000, 8, -1, -1, 0, 1);
    check_eq("post_rst_err", last_err, 0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom & 32'hFFFF_FFF8;
        1:       ra = {20'($urandom), 12'(4096 - 8 * $urandom_range(1, 20))};
        2:       ra = 32'hFFFF_FFF8 - 32'(8 * $urandom_range(0, 10));
        default: ra = 32'(8 * $urandom_range(0, 600));
      endcase
      rb  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 70));
      reb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, rb)) : -1;
      rfb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rb)) : -1;
      run_cmd(ra, rb, reb, rfb, ($urandom_range(0, 2) == 0) ? 2 : 0, 1);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
